// File: rtl/load_store_unit_pkg.sv
// lsu_pkg: shared types, funct3 encodings and access-size decode for the load/store unit.
package lsu_pkg;
    typedef enum logic [2:0] {IDLE, LD_READ, RMW_READ, ST_WRITE, RESP} lsu_state_e;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} ls_size_e;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    // Unlisted encodings (and stores with funct3[1:0]==11) fall through to word access.
    function automatic ls_size_e size_of(input logic [2:0] f3);
        return f3[1:0] == F3_LB[1:0] ? SZ_B : f3[1:0] == F3_LH[1:0] ? SZ_H : SZ_W;
    endfunction
endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: execute-side request/response bundle of the load/store unit.
// resp_misaligned exists only when MISALIGN_TRAP_EN is defined.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
`ifdef MISALIGN_TRAP_EN
    logic        resp_misaligned;
    modport master(output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
                   input req_ready, resp_valid, resp_rdata, resp_rd, resp_misaligned);
    modport slave(input req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
                  output req_ready, resp_valid, resp_rdata, resp_rd, resp_misaligned);
`else
    modport master(output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
                   input req_ready, resp_valid, resp_rdata, resp_rd);
    modport slave(input req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
                  output req_ready, resp_valid, resp_rdata, resp_rd);
`endif
endinterface

// File: rtl/load_store_unit_load_align.sv
// load_align: picks the byte/half lane of a memory word and sign/zero-extends it.
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] value
);
    ls_size_e    sz;
    logic        sgn;
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        sz = size_of(funct3);
        sgn = funct3 != F3_LBU && funct3 != F3_LHU;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        value = sz == SZ_B ? {{24{sgn & b[7]}}, b} : sz == SZ_H ? {{16{sgn & h[15]}}, h} : word;
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: turns RV32I loads/stores into whole-word accesses, sub-word stores via read-modify-write.
// Defining MISALIGN_TRAP_EN adds resp_misaligned and traps misaligned H/W ops without touching memory.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    load_store_unit_if.slave  bus,
    output logic              mem_WE,
    output logic              mem_RE,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_read_data
);
    lsu_state_e  state;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] ld_val, mask, lanes, merged;
    ls_size_e    sz, req_sz;
    logic        trap;
    logic        unused_addr;

    assign unused_addr = ^bus.req_addr[31:ADDR_W+2];
    assign req_sz = size_of(bus.req_funct3);

    load_align u_align (.word(mem_read_data), .off(off), .funct3(f3), .value(ld_val));

    // Byte-lane mask for the pending store; lanes outside it keep the word just read.
    always_comb begin
        sz = size_of(f3);
        mask = sz == SZ_B ? 32'hFF << {off, 3'b000} : sz == SZ_H ? (off[1] ? 32'hFFFF_0000 : 32'h0000_FFFF) : '1;
        lanes = sz == SZ_B ? {4{wdata[7:0]}} : sz == SZ_H ? {2{wdata[15:0]}} : wdata;
        merged = (mem_read_data & ~mask) | (lanes & mask);
    end

`ifdef MISALIGN_TRAP_EN
    assign trap = (req_sz == SZ_H && bus.req_addr[0]) || (req_sz == SZ_W && bus.req_addr[1:0] != 2'b00);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) bus.resp_misaligned <= 1'b0;
        else if (state == IDLE && bus.req_valid) bus.resp_misaligned <= trap;
`else
    assign trap = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            f3             <= '0;
            off            <= '0;
            wdata          <= '0;
            rd             <= '0;
            mem_WE         <= 1'b0;
            mem_RE         <= 1'b0;
            mem_address    <= '0;
            mem_write_data <= '0;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_rd    <= '0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    f3            <= bus.req_funct3;
                    off           <= bus.req_addr[1:0];
                    wdata         <= bus.req_wdata;
                    rd            <= bus.req_rd;
                    bus.req_ready <= 1'b0;
                    if (trap) begin
                        state          <= RESP;
                        bus.resp_valid <= 1'b1;
                        bus.resp_rdata <= '0;
                        bus.resp_rd    <= bus.req_rd;
                    end else begin
                        mem_address <= bus.req_addr[ADDR_W+1:2];
                        if (!bus.req_we) begin
                            state  <= LD_READ;
                            mem_RE <= 1'b1;
                        end else if (req_sz == SZ_W) begin
                            state          <= ST_WRITE;
                            mem_WE         <= 1'b1;
                            mem_write_data <= bus.req_wdata;
                        end else begin
                            state  <= RMW_READ;
                            mem_RE <= 1'b1;
                        end
                    end
                end
                LD_READ: begin
                    state          <= RESP;
                    mem_RE         <= 1'b0;
                    bus.resp_valid <= 1'b1;
                    bus.resp_rdata <= ld_val;
                    bus.resp_rd    <= rd;
                end
                RMW_READ: begin
                    state          <= ST_WRITE;
                    mem_RE         <= 1'b0;
                    mem_WE         <= 1'b1;
                    mem_write_data <= merged;
                end
                ST_WRITE: begin
                    state          <= RESP;
                    mem_WE         <= 1'b0;
                    bus.resp_valid <= 1'b1;
                    bus.resp_rdata <= '0;
                    bus.resp_rd    <= rd;
                end
                RESP: begin
                    state          <= IDLE;
                    bus.resp_valid <= 1'b0;
                    bus.req_ready  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed spec cases plus random ops checked against a byte-level memory model.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_WE, mem_RE;
    logic [9:0]  mem_address;
    logic [31:0] mem_write_data, mem_read_data;
    logic [31:0] mem [1024];
    logic [31:0] ref_mem [1024];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    load_store_unit_if bus();

    load_store_unit #(.ADDR_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .mem_WE(mem_WE), .mem_RE(mem_RE), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    assign mem_read_data = mem[mem_address];
    always @(posedge clk) if (mem_WE) mem[mem_address] <= mem_write_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic bit is_mis(input logic [2:0] f3, input logic [31:0] addr);
`ifdef MISALIGN_TRAP_EN
        return (addr % nbytes(f3)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic set_word(input int i, input logic [31:0] w);
        mem[i] = w;
        ref_mem[i] = w;
    endtask

    task automatic do_op(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd);
        int n, off, lat, exp_lat, re_n, we_n;
        bit mis, both, bad_addr, got_mis;
        logic [9:0]  idx;
        logic [31:0] m, exp_rdata, got_rdata;
        logic [4:0]  got_rd;
        n = nbytes(f3);
        idx = addr[11:2];
        mis = is_mis(f3, addr);
        off = n == 4 ? 0 : n == 2 ? int'(addr & 32'd2) : int'(addr & 32'd3);
        exp_rdata = '0;
        if (mis) exp_lat = 1;
        else if (!we) begin
            m = n == 4 ? 32'hFFFF_FFFF : (32'd1 << (8 * n)) - 32'd1;
            exp_rdata = (ref_mem[idx] >> (8 * off)) & m;
            if (n < 4 && !f3[2] && exp_rdata[8 * n - 1]) exp_rdata = exp_rdata | ~m;
            exp_lat = 2;
        end else begin
            for (int i = 0; i < n; i++) ref_mem[idx][8 * (off + i) +: 8] = wdata[8 * i +: 8];
            exp_lat = n == 4 ? 2 : 3;
        end
        bus.req_valid = 1'b1;
        bus.req_we = we;
        bus.req_funct3 = f3;
        bus.req_addr = addr;
        bus.req_wdata = wdata;
        bus.req_rd = rd;
        @(posedge clk);
        lat = 0; re_n = 0; we_n = 0; both = 0; bad_addr = 0; got_mis = 0;
        got_rdata = 'x; got_rd = 'x;
        for (int c = 1; c <= 8 && lat == 0; c++) begin
            @(negedge clk);
            re_n += int'(mem_RE);
            we_n += int'(mem_WE);
            if (mem_RE && mem_WE) both = 1;
            if ((mem_RE || mem_WE) && mem_address !== idx) bad_addr = 1;
            if (c == 1) check("busy_ready", 32'(bus.req_ready), 0);
            if (bus.resp_valid) begin
                lat = c;
                got_rdata = bus.resp_rdata;
                got_rd = bus.resp_rd;
`ifdef MISALIGN_TRAP_EN
                got_mis = bus.resp_misaligned;
`endif
            end else begin
                bus.req_valid = 1'b1;
                bus.req_we = 1'($urandom);
                bus.req_funct3 = 3'($urandom);
                bus.req_addr = $urandom;
                bus.req_wdata = $urandom;
            end
        end
        bus.req_valid = 1'b0;
        check("latency", lat, exp_lat);
        check("rdata", got_rdata, exp_rdata);
        check("rd", 32'(got_rd), 32'(rd));
        check("re_count", re_n, int'(!mis && (!we || n < 4)));
        check("we_count", we_n, int'(!mis && we));
        check("re_we_exclusive", 32'(both), 0);
        check("mem_address", 32'(bad_addr), 0);
        check("misaligned", 32'(got_mis), 32'(mis));
        @(negedge clk);
        check("ready_after", 32'(bus.req_ready), 1);
        check("resp_one_cycle", 32'(bus.resp_valid), 0);
        check("word", mem[idx], ref_mem[idx]);
    endtask

    task automatic reset_mid_rmw();
        bit seen;
        set_word(2, 32'h1122_3344);
        bus.req_valid = 1'b1;
        bus.req_we = 1'b1;
        bus.req_funct3 = 3'b000;
        bus.req_addr = 32'h09;
        bus.req_wdata = 32'hAB;
        bus.req_rd = 5'd3;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("rmw_re", 32'(mem_RE), 1);
        @(negedge clk);
        check("rmw_we", 32'(mem_WE), 1);
        check("rmw_wdata", mem_write_data, 32'h1122_AB44);
        #1 rst_n = 1'b0;
        #1;
        check("rst_we", 32'(mem_WE), 0);
        check("rst_ready", 32'(bus.req_ready), 1);
        check("rst_resp", 32'(bus.resp_valid), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            seen |= bus.resp_valid;
        end
        check("rst_no_resp", 32'(seen), 0);
        check("rst_word", mem[2], 32'h1122_3344);
        check("rst_ready_after", 32'(bus.req_ready), 1);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_we = 1'b0;
        bus.req_funct3 = '0;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        bus.req_rd = '0;
        for (int i = 0; i < 1024; i++) set_word(i, $urandom);
        #12;
        check("reset_ready", 32'(bus.req_ready), 1);
        check("reset_resp_valid", 32'(bus.resp_valid), 0);
        check("reset_re", 32'(mem_RE), 0);
        check("reset_we", 32'(mem_WE), 0);
        check("reset_address", 32'(mem_address), 0);
        check("reset_rdata", bus.resp_rdata, 0);
`ifdef MISALIGN_TRAP_EN
        check("reset_misaligned", 32'(bus.resp_misaligned), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        set_word(5, 32'hDEAD_BEEF);
        do_op(0, 3'b010, 32'h14, 0, 5'd7);
        do_op(0, 3'b000, 32'h17, 0, 5'd1);
        do_op(0, 3'b100, 32'h17, 0, 5'd2);
        do_op(0, 3'b001, 32'h16, 0, 5'd3);
        set_word(2, 32'h1122_3344);
        do_op(1, 3'b000, 32'h09, 32'hAB, 5'd4);
        set_word(2, 32'h1122_3344);
        do_op(1, 3'b001, 32'h0A, 32'hBEEF, 5'd5);
        do_op(0, 3'b010, 32'h08, 0, 5'd6);
        reset_mid_rmw();
        do_op(0, 3'b010, 32'h02, 0, 5'd8);
        do_op(1, 3'b010, 32'h0E, 32'hCAFE_F00D, 5'd9);
        for (int k = 0; k < 200; k++)
            do_op(1'($urandom), 3'($urandom), $urandom, $urandom, 5'($urandom));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
